// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: Decode/Execute/writeback inputs and hazard bubble outputs of the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3,
    parameter int NWB   = 2,
    parameter int SC_W  = 16
);
    logic [AW-1:0]     rs1_D, rs2_D, rd_D, issue_rd_E;
    logic              rs1_used_D, rs2_used_D, rd_we_D;
    logic              issue_valid_E, issue_we_E, flush_E;
    logic [LAT_W-1:0]  issue_lat_E;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*AW-1:0] wb_rd;
    logic              StallF, StallD, FlushE, fwdok1_D, fwdok2_D;
    logic [NREG-1:0]   pending_o;
    logic [SC_W-1:0]   stall_count;

    modport master (
        output rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, rd_we_D,
        output issue_valid_E, issue_we_E, issue_rd_E, issue_lat_E, flush_E,
        output wb_valid, wb_rd,
        input  StallF, StallD, FlushE, fwdok1_D, fwdok2_D, pending_o, stall_count
    );
    modport slave (
        input  rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, rd_we_D,
        input  issue_valid_E, issue_we_E, issue_rd_E, issue_lat_E, flush_E,
        input  wb_valid, wb_rd,
        output StallF, StallD, FlushE, fwdok1_D, fwdok2_D, pending_o, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending bit plus latency countdown driving Decode stall/flush and forward hints.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3,
    parameter int NWB   = 2,
    parameter int SC_W  = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    logic [NREG-1:0]  pend, ret;
    logic [LAT_W-1:0] cnt [NREG];
    logic [LAT_W-1:0] issue_cnt;
    logic [SC_W-1:0]  sc;
    logic             issue, use1, use2, rawe1, rawe2, waw, hazard;

    assign issue = sb.issue_valid_E & sb.issue_we_E & ~sb.flush_E & (sb.issue_rd_E != '0);
    assign issue_cnt = (sb.issue_lat_E != '0) ? sb.issue_lat_E - LAT_W'(1) : '0;

    always_comb begin
        ret = '0;
        for (int i = 0; i < NWB; i++)
            if (sb.wb_valid[i]) ret[sb.wb_rd[i*AW +: AW]] = 1'b1;
    end

    // Issue beats retire so a newer producer of the same rd is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && sb.issue_rd_E == AW'(r)) begin
                    pend[r] <= 1'b1;
                    cnt[r]  <= issue_cnt;
                end else if (ret[r]) begin
                    pend[r] <= 1'b0;
                    cnt[r]  <= '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        use1   = sb.rs1_used_D && sb.rs1_D != '0;
        use2   = sb.rs2_used_D && sb.rs2_D != '0;
        rawe1  = issue && sb.issue_rd_E == sb.rs1_D && sb.issue_lat_E != '0;
        rawe2  = issue && sb.issue_rd_E == sb.rs2_D && sb.issue_lat_E != '0;
        waw    = sb.rd_we_D && sb.rd_D != '0 && pend[sb.rd_D] && cnt[sb.rd_D] != '0;
        hazard = reset && (waw
               || (use1 && (rawe1 || (pend[sb.rs1_D] && cnt[sb.rs1_D] != '0)))
               || (use2 && (rawe2 || (pend[sb.rs2_D] && cnt[sb.rs2_D] != '0))));
    end

    assign sb.StallF      = hazard;
    assign sb.StallD      = hazard;
    assign sb.FlushE      = hazard;
    assign sb.fwdok1_D    = reset && use1 && !rawe1 && pend[sb.rs1_D] && cnt[sb.rs1_D] == '0;
    assign sb.fwdok2_D    = reset && use2 && !rawe2 && pend[sb.rs2_D] && cnt[sb.rs2_D] == '0;
    assign sb.pending_o   = pend;
    assign sb.stall_count = sc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sc <= '0;
        else if (hazard && sc != '1) sc <= sc + SC_W'(1);
    end
endmodule
